ysyx_22041207_fetch_queue: RTL and testbench
============================================

# ysyx_22041207_fetch_queue

Decoupling FIFO between the instruction-fetch stage and the decode stage of the ysyx_22041207 RV64 pipeline. It buffers fetched {pc, inst, fault} entries so that a decode stall does not immediately freeze the fetch PC, and it discards every buffered entry when a redirect occurs (jal/jalr/taken branch/trap). Decode consumes the head entry through a valid/ready handshake.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- CNT_W, $clog2(DEPTH)+1, width of `count`

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  queue can accept an entry: `count != DEPTH`
- in_pc  in  64  PC of the fetched instruction
- in_inst  in  32  fetched instruction word
- in_fault  in  1  instruction access fault for this PC
- flush  in  1  redirect; drop all entries
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts the head entry
- out_pc  out  64  head PC; 0 when `out_valid` = 0
- out_inst  out  32  head instruction; 32'h00000013 (NOP) when `out_valid` = 0
- out_fault  out  1  head fault; 0 when `out_valid` = 0
- count  out  CNT_W  number of occupied entries

## Operation
- Enqueue on `in_valid && in_ready && !flush`; dequeue on `out_valid && out_ready && !flush`.
- Circular storage with rd_ptr/wr_ptr of log2(DEPTH) bits. Pointers wrap modulo DEPTH; `count` disambiguates full from empty.
- Simultaneous enqueue and dequeue: `count` is unchanged, both pointers advance. This is legal at any occupancy below DEPTH.
- Full: `in_ready` = 0. `in_ready` depends only on registered `count` and has no combinational path from `out_ready`, so a dequeue in the full cycle does not open a slot until the next cycle.
- Empty: `out_valid` = 0. A dequeue attempt has no effect.
- `flush` has priority over everything. On that edge, `count`, rd_ptr and wr_ptr all return to 0. Any concurrent enqueue or dequeue is ignored. A fault entry is treated like any other entry.
- Reset (asynchronous assert at any time, including mid-transfer): `count` = 0, pointers = 0, `out_valid` = 0, `out_pc` = 0, `out_inst` = NOP, `out_fault` = 0, `in_ready` = 1. Storage contents are don't-care.

## Timing
- Without bypass: an entry written at edge N is visible on `out_*` after edge N, so latency is 1 cycle.
- Throughput: 1 entry/cycle sustained when neither side stalls.
- `out_*` are driven from the head entry through the empty mask only; there is no path from `in_*` to `out_*` unless the bypass is compiled in.
- The cycle after `flush` is sampled: `out_valid` = 0 and `count` = 0. An enqueue in that same following cycle is accepted normally.
- `in_ready` and `out_valid` are functions of registered state only (the bypass is the exception, see below).

## Configuration
- `YSYX_22041207_FETCH_QUEUE_BYPASS_EN` defined: when `count` = 0 and `in_valid && !flush`, the input is forwarded combinationally to `out_*` with `out_valid` = 1.
  - If `out_ready` is also 1 in that cycle, the entry is consumed and not written; `count` stays 0.
  - Otherwise the entry is written normally.
  - Latency for an empty queue becomes 0.
- Undefined: no bypass; behaviour is exactly as described under Timing.

## Structure
- Shared package `ysyx_22041207_pkg`:
  - `NOP_INST` = 32'h00000013.
  - `fetch_entry_t` packed struct {pc[63:0], inst[31:0], fault}.
  - `RESET_PC` = 64'h80000000, which the bench uses for the PC sequence.
- One natural sub-module: `ysyx_22041207_fq_mem`, a DEPTH x `fetch_entry_t` register array with one write port and one asynchronous read port.
- Pointers, count and handshake logic live in the top module.

## Test plan
- Reset, then 4 enqueues of PC 0x80000000..0x8000000C with `out_ready` = 0 -> `count` = 4, `in_ready` = 0; a 5th `in_valid` is not accepted; head `out_pc` = 0x80000000.
- Hold `out_ready` = 1 with streaming input for 10 cycles -> one entry delivered per cycle, PCs increment by 4, `count` constant, pointers wrap past DEPTH without loss.
- Queue holding 3 entries, `flush` = 1 with `in_valid` = 1 and `out_ready` = 1 -> next cycle `count` = 0, `out_valid` = 0, `out_inst` = 0x00000013; the flushed-cycle input never appears.
- Full queue, `out_ready` = 1 for one cycle -> `count` = 3 after the edge, `in_ready` rises in that following cycle and not earlier.
- Enqueue with `in_fault` = 1 at PC 0x80000010 -> dequeued entry has `out_fault` = 1 and `out_pc` = 0x80000010; neighbouring entries have `out_fault` = 0.
- Assert `rst_n` low asynchronously mid-stream with `count` = 2 -> outputs go to their reset values before the next clock edge; with `YSYX_22041207_FETCH_QUEUE_BYPASS_EN` defined, an empty-queue enqueue with `out_ready` = 1 shows `out_valid` = 1 in the same cycle and `count` stays 0.

Source files
------------

// File: rtl/ysyx_22041207_pkg.sv
// Shared ysyx_22041207 pipeline types: fetch entry layout, NOP encoding, boot PC.
package ysyx_22041207_pkg;

  localparam logic [31:0] NOP_INST = 32'h00000013;
  localparam logic [63:0] RESET_PC = 64'h80000000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/ysyx_22041207_fetch_queue_if.sv
// Fetch->decode handshake bundle; master = fetch/decode side, slave = the queue.
interface ysyx_22041207_fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_pc;
  logic [31:0]      in_inst;
  logic             in_fault;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_pc;
  logic [31:0]      out_inst;
  logic             out_fault;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, in_pc, in_inst, in_fault, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_fault, count
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_fault, flush, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_fault, count
  );
endinterface

// File: rtl/ysyx_22041207_fq_mem.sv
// DEPTH x fetch_entry_t register file: one synchronous write port, one async read port.
module ysyx_22041207_fq_mem
  import ysyx_22041207_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  fetch_entry_t     i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output fetch_entry_t     o_rdata
);

  fetch_entry_t r_mem [DEPTH];

  // Contents are don't-care after reset; occupancy lives in the top's count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    always_ff @(posedge clk) begin
      if (i_we && (i_waddr == PTR_W'(g))) r_mem[g] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ysyx_22041207_fetch_queue.sv
// Fetch->decode decoupling FIFO with flush-on-redirect.
// Optional empty-queue bypass: define YSYX_22041207_FETCH_QUEUE_BYPASS_EN.
module ysyx_22041207_fetch_queue
  import ysyx_22041207_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ysyx_22041207_fetch_queue_if.slave  fq
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic         w_empty;
  logic         w_in_ready;
  logic         w_out_valid;
  logic         w_byp;
  logic         w_enq;
  logic         w_deq;
  logic         w_wr;
  logic         w_rd;
  fetch_entry_t w_in_ent;
  fetch_entry_t w_mem_ent;
  fetch_entry_t w_head;

  assign w_empty    = (r_count == '0);
  assign w_in_ready = (r_count != FULL_CNT);
  assign w_in_ent   = '{pc: fq.in_pc, inst: fq.in_inst, fault: fq.in_fault};

`ifdef YSYX_22041207_FETCH_QUEUE_BYPASS_EN
  assign w_byp = w_empty & fq.in_valid & ~fq.flush;
`else
  assign w_byp = 1'b0;
`endif

  assign w_out_valid = ~w_empty | w_byp;
  assign w_head      = w_byp ? w_in_ent : w_mem_ent;

  assign w_enq = fq.in_valid & w_in_ready & ~fq.flush;
  assign w_deq = w_out_valid & fq.out_ready & ~fq.flush;
  // A bypassed entry taken by decode in the same cycle never touches storage.
  assign w_wr  = w_enq & ~(w_byp & fq.out_ready);
  assign w_rd  = w_deq & ~w_empty;

  ysyx_22041207_fq_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_in_ent),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_ent)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (fq.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Outputs are masked to idle values whenever nothing is presented.
  assign fq.in_ready  = w_in_ready;
  assign fq.out_valid = w_out_valid;
  assign fq.out_pc    = w_out_valid ? w_head.pc    : 64'd0;
  assign fq.out_inst  = w_out_valid ? w_head.inst  : NOP_INST;
  assign fq.out_fault = w_out_valid ? w_head.fault : 1'b0;
  assign fq.count     = r_count;

endmodule

// File: tb/tb_ysyx_22041207_fetch_queue.sv
// Directed bench for the fetch queue with a queue-based reference model.
module tb_ysyx_22041207_fetch_queue;
  import ysyx_22041207_pkg::*;

  localparam int DEPTH = 4;
`ifdef YSYX_22041207_FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [63:0] RP = RESET_PC;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  ysyx_22041207_fetch_queue_if #(.DEPTH(DEPTH)) fq ();

  ysyx_22041207_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fq    (fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the queue contents as a plain list of entries.
  fetch_entry_t mq[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mq.delete();
    else if (fq.flush) mq.delete();
    else begin
      int sz;
      bit byp, take, give;
      fetch_entry_t e;
      sz   = mq.size();
      byp  = BYP && sz == 0 && fq.in_valid;
      take = fq.in_valid && sz < DEPTH;
      give = fq.out_ready && (sz > 0 || byp);
      e    = '{pc: fq.in_pc, inst: fq.in_inst, fault: fq.in_fault};
      if (give && sz > 0) void'(mq.pop_front());
      if (take && !(byp && give)) mq.push_back(e);
    end
  end

  always @(negedge clk) begin
    int sz;
    bit byp, ev;
    fetch_entry_t h;
    sz  = mq.size();
    byp = BYP && sz == 0 && fq.in_valid && !fq.flush && rst_n;
    ev  = sz > 0 || byp;
    h   = '{pc: fq.in_pc, inst: fq.in_inst, fault: fq.in_fault};
    if (sz > 0) h = mq[0];
    chk("m_out_valid", 64'(fq.out_valid), 64'(ev));
    chk("m_in_ready",  64'(fq.in_ready),  64'(sz != DEPTH));
    chk("m_count",     64'(fq.count),     64'(sz));
    chk("m_out_pc",    fq.out_pc,         ev ? h.pc : 64'd0);
    chk("m_out_inst",  64'(fq.out_inst),  64'(ev ? h.inst : NOP_INST));
    chk("m_out_fault", 64'(fq.out_fault), 64'(ev ? h.fault : 1'b0));
  end

  task automatic drv(input bit v, input logic [63:0] pc, input bit f, input bit ordy, input bit fl);
    fq.in_valid  = v;
    fq.in_pc     = pc;
    fq.in_inst   = pc[31:0] ^ 32'h00000093;
    fq.in_fault  = f;
    fq.out_ready = ordy;
    fq.flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(0, 64'd0, 0, 0, 0);
    #12;
    chk("rst_out_valid", 64'(fq.out_valid), 64'd0);
    chk("rst_out_inst",  64'(fq.out_inst),  64'h13);
    chk("rst_out_pc",    fq.out_pc,         64'd0);
    chk("rst_count",     64'(fq.count),     64'd0);
    chk("rst_in_ready",  64'(fq.in_ready),  64'd1);
    rst_n = 1'b1;
    tick();

    // Fill to DEPTH with decode stalled.
    for (int i = 0; i < 4; i++) begin
      drv(1, RP + 64'(4 * i), 0, 0, 0);
      tick();
    end
    chk("full_count",    64'(fq.count),    64'd4);
    chk("full_in_ready", 64'(fq.in_ready), 64'd0);
    chk("full_head_pc",  fq.out_pc,        64'h80000000);
    drv(1, RP + 64'h10, 0, 0, 0);
    tick();
    chk("fifth_count", 64'(fq.count), 64'd4);
    chk("fifth_head",  fq.out_pc,     64'h80000000);

    // One dequeue while full: the slot opens only after the edge.
    drv(1, RP + 64'h10, 0, 1, 0);
    chk("full_deq_ready_pre", 64'(fq.in_ready), 64'd0);
    tick();
    drv(0, 64'd0, 0, 0, 0);
    chk("full_deq_count", 64'(fq.count),    64'd3);
    chk("full_deq_ready", 64'(fq.in_ready), 64'd1);
    chk("full_deq_head",  fq.out_pc,        64'h80000004);

    // Flush with 3 entries and concurrent enqueue/dequeue.
    drv(1, 64'hdead, 0, 1, 1);
    tick();
    drv(0, 64'd0, 0, 0, 0);
    chk("flush_count", 64'(fq.count),     64'd0);
    chk("flush_valid", 64'(fq.out_valid), 64'd0);
    chk("flush_inst",  64'(fq.out_inst),  64'h13);

    // Fault entry between two clean ones.
    drv(1, RP + 64'h0C, 0, 0, 0); tick();
    drv(1, RP + 64'h10, 1, 0, 0); tick();
    drv(1, RP + 64'h14, 0, 0, 0); tick();
    drv(0, 64'd0, 0, 1, 0);
    chk("flt_count", 64'(fq.count), 64'd3);
    chk("flt0_pc", fq.out_pc, 64'h8000000C);
    chk("flt0_f",  64'(fq.out_fault), 64'd0);
    tick();
    chk("flt1_pc", fq.out_pc, 64'h80000010);
    chk("flt1_f",  64'(fq.out_fault), 64'd1);
    tick();
    chk("flt2_pc", fq.out_pc, 64'h80000014);
    chk("flt2_f",  64'(fq.out_fault), 64'd0);
    tick();
    chk("flt_empty", 64'(fq.out_valid), 64'd0);

    // Streaming, pointers wrap several times.
    for (int k = 0; k < 12; k++) begin
      drv(1, RP + 64'h100 + 64'(4 * k), 0, 1, 0);
      tick();
    end
    chk("stream_count", 64'(fq.count), BYP ? 64'd0 : 64'd1);
    chk("stream_head",  fq.out_pc,     64'h8000012C);

    // Async reset mid-stream with two entries held.
    drv(0, 64'd0, 0, 1, 0); tick();
    drv(1, RP + 64'h200, 0, 0, 0); tick();
    drv(1, RP + 64'h204, 0, 0, 0); tick();
    drv(0, 64'd0, 0, 0, 0);
    chk("pre_rst_count", 64'(fq.count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(fq.out_valid), 64'd0);
    chk("arst_count", 64'(fq.count),     64'd0);
    chk("arst_ready", 64'(fq.in_ready),  64'd1);
    chk("arst_pc",    fq.out_pc,         64'd0);
    chk("arst_inst",  64'(fq.out_inst),  64'h13);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Empty-queue enqueue with decode ready: same-cycle only with bypass.
    drv(1, RP + 64'h300, 0, 1, 0);
    #1;
    chk("byp_valid", 64'(fq.out_valid), BYP ? 64'd1 : 64'd0);
    chk("byp_pc",    fq.out_pc,         BYP ? 64'h80000300 : 64'd0);
    tick();
    drv(0, 64'd0, 0, 1, 0);
    chk("byp_count", 64'(fq.count), BYP ? 64'd0 : 64'd1);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
